// File: rtl/l2_cache.sv
// rtl/l2_cache.sv - write-back, write-allocate, set-associative L2 cache with block-wide L1 and memory ports
module l2_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 4096,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            l1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out,
    input  logic                             l1_read,
    input  logic                             l1_write,
    output logic                             l1_ready,
    output logic                             l1_hit,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic                             mem_ready
);

    localparam int BW     = BLOCK_SIZE * DATA_WIDTH;
    localparam int SETS   = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int BLK_W  = ADDR_WIDTH - OFF_W;
    localparam int TAG_W  = BLK_W - IDX_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINES  = SETS * NUM_WAYS;
    localparam int LINE_W = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Request latched in IDLE; only the block part of the address matters
    logic [BLK_W-1:0]    r_blk;
    logic                r_is_write;
    logic [BW-1:0]       r_wdata;
    logic [BW-1:0]       r_rdata;
    logic                r_hit;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BW-1:0]       r_mem_wdata;
    logic [WAY_W-1:0]    r_victim;

    // Line storage: tag/data need no reset, valid/dirty/pointer do
    logic [TAG_W-1:0]    r_tag   [LINES];
    logic [BW-1:0]       r_data  [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [WAY_W-1:0]    r_ptr   [SETS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_inv_found;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_victim;
    logic [LINE_W-1:0]   w_hit_line;
    logic [LINE_W-1:0]   w_vic_line;
    logic [LINE_W-1:0]   w_vic_line_r;
    logic                w_vic_dirty;
    logic                w_evict_done;
    logic                w_fill_done;
    logic                w_we;
    logic [LINE_W-1:0]   w_we_line;
    logic [TAG_W-1:0]    w_we_tag;
    logic [BW-1:0]       w_we_data;
    logic                w_unused_off;

    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx,
                                                  input logic [WAY_W-1:0] way);
        line_of = LINE_W'(idx) * LINE_W'(NUM_WAYS) + LINE_W'(way);
    endfunction

    assign w_unused_off = ^l1_addr[OFF_W-1:0];
    assign w_idx        = r_blk[IDX_W-1:0];
    assign w_tag        = r_blk[BLK_W-1 -: TAG_W];
    assign w_hit_line   = line_of(w_idx, w_hit_way);
    assign w_victim     = w_inv_found ? w_inv_way : r_ptr[w_idx];
    assign w_vic_line   = line_of(w_idx, w_victim);
    assign w_vic_line_r = line_of(w_idx, r_victim);
    assign w_vic_dirty  = r_valid[w_vic_line] && r_dirty[w_vic_line];
    // mem_ready only counts while this cache is actually driving a request
    assign w_evict_done = (r_state == S_EVICT) && r_mem_write && mem_ready;
    assign w_fill_done  = (r_state == S_FILL)  && r_mem_read  && mem_ready;

    // Tag match across the set and lowest-index invalid way
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[line_of(w_idx, WAY_W'(w))] &&
                (r_tag[line_of(w_idx, WAY_W'(w))] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[line_of(w_idx, WAY_W'(w))] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    // Line write port: write hit, write-miss install, or fill
    always_comb begin
        w_we      = 1'b0;
        w_we_line = w_hit_line;
        w_we_tag  = w_tag;
        w_we_data = r_wdata;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    w_we = r_is_write;
                end else if (r_is_write && !w_vic_dirty) begin
                    w_we      = 1'b1;
                    w_we_line = w_vic_line;
                end
            end
            S_EVICT: begin
                if (w_evict_done && r_is_write) begin
                    w_we      = 1'b1;
                    w_we_line = w_vic_line_r;
                end
            end
            S_FILL: begin
                if (w_fill_done) begin
                    w_we      = 1'b1;
                    w_we_line = w_vic_line_r;
                    w_we_data = mem_data_in;
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (l1_read || l1_write) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)            w_next = S_RESPOND;
                else if (w_vic_dirty) w_next = S_EVICT;
                else if (r_is_write)  w_next = S_RESPOND;
                else                  w_next = S_FILL;
            end
            S_EVICT:   if (w_evict_done) w_next = r_is_write ? S_RESPOND : S_FILL;
            S_FILL:    if (w_fill_done)  w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs: ready pulse from state, everything else from held registers
    always_comb begin
        l1_ready     = (r_state == S_RESPOND);
        l1_hit       = r_hit;
        l1_data_out  = r_rdata;
        mem_read     = r_mem_read;
        mem_write    = r_mem_write;
        mem_addr     = r_mem_addr;
        mem_data_out = r_mem_wdata;
    end

    // Request latch, line status, replacement pointers and memory handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk       <= '0;
            r_is_write  <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_hit       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_victim    <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else begin
            if (w_we) begin
                r_valid[w_we_line] <= 1'b1;
                r_dirty[w_we_line] <= (r_state != S_FILL);
            end
            case (r_state)
                S_IDLE: begin
                    if (l1_read || l1_write) begin
                        r_blk      <= l1_addr[ADDR_WIDTH-1:OFF_W];
                        r_is_write <= l1_write;
                        r_wdata    <= l1_data_in;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_hit <= 1'b1;
                        if (!r_is_write) r_rdata <= r_data[w_hit_line];
                    end else begin
                        r_hit    <= 1'b0;
                        r_victim <= w_victim;
                        if (!w_inv_found)
                            r_ptr[w_idx] <= (r_ptr[w_idx] == WAY_W'(NUM_WAYS - 1)) ?
                                            '0 : r_ptr[w_idx] + WAY_W'(1);
                        if (w_vic_dirty) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_vic_line], w_idx, {OFF_W{1'b0}}};
                            r_mem_wdata <= r_data[w_vic_line];
                        end
                    end
                end
                S_EVICT: begin
                    if (w_evict_done) begin
                        r_mem_write <= 1'b0;
                        if (!r_is_write) r_dirty[w_vic_line_r] <= 1'b0;
                    end
                end
                S_FILL: begin
                    // mem_read rises one cycle after FILL entry, so it never follows mem_ready directly
                    if (w_fill_done) begin
                        r_mem_read <= 1'b0;
                        r_rdata    <= mem_data_in;
                    end else if (!r_mem_read) begin
                        r_mem_read <= 1'b1;
                        r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data array write
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_tag[w_we_line]  <= w_we_tag;
            r_data[w_we_line] <= w_we_data;
        end
    end

endmodule
